// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with grant hold and optional hold limit.
// A grant is held until the owner drops its request, enable falls, or the
// hold limit expires. Priority then rotates to the index after the last owner.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNTW     = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       expired
);

    localparam int unsigned NREQ    = 8;
    localparam int unsigned IDXW    = 3;
    localparam bit          HOLD_EN = (MAX_HOLD != 0);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDXW-1:0]   ptr;
    logic [IDXW-1:0]   ptr_nxt;
    logic [CNTW-1:0]   hold_cnt;
    logic [CNTW-1:0]   cnt_nxt;

    logic [NREQ-1:0]   rot_req;
    logic [2*NREQ-1:0] req_dbl;
    logic [IDXW-1:0]   first_off;
    logic [IDXW-1:0]   sel;
    logic              grant_new;
    logic              release_now;
    logic              expire_now;

    logic [NREQ-1:0]   gnt_nxt;
    logic [IDXW-1:0]   idx_nxt;
    logic              valid_nxt;
    logic              expired_nxt;

    // Lowest set bit of a vector as a 3-bit index (8-to-3 priority encode).
    function automatic logic [IDXW-1:0] prio_enc8(input logic [NREQ-1:0] v);
        logic [IDXW-1:0] r;
        r = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (v[i]) r = IDXW'(i);
        end
        return r;
    endfunction

    // Rotate requests so that ptr lands on bit 0, encode, then rotate back.
    always_comb begin
        req_dbl   = {req, req};
        rot_req   = NREQ'(req_dbl >> ptr);
        first_off = prio_enc8(rot_req);
        sel       = ptr + first_off;
    end

    // State, pointer and hold counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= cnt_nxt;
        end
    end

    // Next-state logic: grant start, hold, release and expiry decisions.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        cnt_nxt     = hold_cnt;
        grant_new   = 1'b0;
        release_now = 1'b0;
        expire_now  = 1'b0;
        case (state)
            IDLE: begin
                if (en && (req != '0)) begin
                    grant_new = 1'b1;
                    cnt_nxt   = CNTW'(1);
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!en || !req[gnt_idx]) begin
                    release_now = 1'b1;
                end else if (HOLD_EN && (hold_cnt == CNTW'(MAX_HOLD))) begin
                    release_now = 1'b1;
                    expire_now  = 1'b1;
                end else if (hold_cnt != '1) begin
                    cnt_nxt = hold_cnt + CNTW'(1);
                end
                if (release_now) begin
                    state_nxt = IDLE;
                    ptr_nxt   = gnt_idx + IDXW'(1);
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output next values; every output is registered.
    always_comb begin
        gnt_nxt     = gnt;
        idx_nxt     = gnt_idx;
        valid_nxt   = gnt_valid;
        expired_nxt = expire_now;
        if (grant_new) begin
            gnt_nxt   = NREQ'(1) << sel;
            idx_nxt   = sel;
            valid_nxt = 1'b1;
        end else if (release_now) begin
            gnt_nxt   = '0;
            idx_nxt   = '0;
            valid_nxt = 1'b0;
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            expired   <= 1'b0;
        end else begin
            gnt       <= gnt_nxt;
            gnt_idx   <= idx_nxt;
            gnt_valid <= valid_nxt;
            expired   <= expired_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8 with a hold limit of 4 cycles.
module tb_rr_arbiter8;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       expired;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       expired;

    int   checks;
    int   errors;
    int   cycle_no;
    exp_t exp_q[$];

    rr_arbiter8 #(.MAX_HOLD(4), .CNTW(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .expired   (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: after each rising edge, pop the expected response and compare.
    initial begin
        exp_t e;
        cycle_no = 0;
        forever begin
            @(posedge clk);
            #1;
            cycle_no++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({gnt, gnt_idx, gnt_valid, expired} !== e) begin
                    errors++;
                    $display("FAIL cycle%0d: gnt=%h idx=%0d valid=%b expired=%b, required gnt=%h idx=%0d valid=%b expired=%b",
                             cycle_no, gnt, gnt_idx, gnt_valid, expired,
                             e.gnt, e.idx, e.valid, e.expired);
                end
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic cyc(input logic e_en, input logic [7:0] e_req,
                       input logic [7:0] x_gnt, input logic [2:0] x_idx,
                       input logic x_valid, input logic x_exp);
        exp_t x;
        en  = e_en;
        req = e_req;
        x.gnt     = x_gnt;
        x.idx     = x_idx;
        x.valid   = x_valid;
        x.expired = x_exp;
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    // Direct comparison of outputs at the current time (no clock edge).
    task automatic check_now(input string name, input logic [7:0] x_gnt,
                             input logic [2:0] x_idx, input logic x_valid,
                             input logic x_exp);
        checks++;
        if ({gnt, gnt_idx, gnt_valid, expired} !== {x_gnt, x_idx, x_valid, x_exp}) begin
            errors++;
            $display("FAIL %s: gnt=%h idx=%0d valid=%b expired=%b, required gnt=%h idx=%0d valid=%b expired=%b",
                     name, gnt, gnt_idx, gnt_valid, expired, x_gnt, x_idx, x_valid, x_exp);
        end
    endtask

    initial begin
        int wait_cnt;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        en     = 1'b1;
        req    = 8'hFF;
        #2;
        check_now("reset_async", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);

        // Reset held with every request raised: outputs stay clear.
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Rotation with all requests: 4 grant cycles then 1 idle with expired.
        for (int g = 0; g < 9; g++) begin
            for (int h = 0; h < 4; h++)
                cyc(1'b1, 8'hFF, 8'h01 << (g % 8), 3'(g % 8), 1'b1, 1'b0);
            cyc(1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b1);
        end
        // ptr is now 1.

        // Single request, drop, then index 1 wins with ptr=1.
        cyc(1'b1, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0);
        cyc(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        cyc(1'b1, 8'h03, 8'h02, 3'd1, 1'b1, 1'b0);
        cyc(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

        // Wrap search: grant 3, release, then 0x0A resolves to index 1.
        cyc(1'b1, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0);
        cyc(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        cyc(1'b1, 8'h0A, 8'h02, 3'd1, 1'b1, 1'b0);
        cyc(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

        // Enable drop during a grant to 5, blocked while low, resume at ptr=6.
        cyc(1'b1, 8'h20, 8'h20, 3'd5, 1'b1, 1'b0);
        cyc(1'b0, 8'h20, 8'h00, 3'd0, 1'b0, 1'b0);
        cyc(1'b0, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0);
        cyc(1'b0, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0);
        cyc(1'b1, 8'hFF, 8'h40, 3'd6, 1'b1, 1'b0);
        cyc(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

        // Request drop coinciding with hold limit: normal release, no expired.
        for (int h = 0; h < 4; h++) cyc(1'b1, 8'h80, 8'h80, 3'd7, 1'b1, 1'b0);
        cyc(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

        // Async reset while index 4 holds the grant.
        cyc(1'b1, 8'h10, 8'h10, 3'd4, 1'b1, 1'b0);
        check_now("pre_reset_grant", 8'h10, 3'd4, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_now("reset_mid_grant", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        cyc(1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc(1'b1, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b0);
        en  = 1'b0;
        req = 8'h00;

        // Drain the scoreboard with a bounded wait.
        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Eight-requester round-robin arbiter with grant hold, built around the team's 8-to-3 priority-encoding logic.
- Shares one resource, such as a bus or encoder output path, among eight requesters.
- Issues a registered one-hot grant plus an encoded index.
- Holds the grant until the owner drops its request, the enable falls, or an optional hold limit expires. Then it rotates priority past the last owner.

Parameters:
- MAX_HOLD, default 16: maximum consecutive grant cycles per owner. 0 disables the limit.
- CNTW, default 5: hold counter width. Must hold MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  arbiter enable. 0 blocks new grants and releases any current grant.
- req  input  8  request vector. Bit i = requester i, active high, level sensitive.
- gnt  output  8  one-hot grant, registered.
- gnt_idx  output  3  binary index of the granted requester. Valid only when gnt_valid=1, otherwise 0.
- gnt_valid  output  1  high while any grant is held.
- expired  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- One clock domain. Reset is asynchronous and active-low, named rst_n; clock named clk.
- Reset values (immediate on rst_n=0, including mid-grant):
  - gnt=0, gnt_idx=0, gnt_valid=0, expired=0.
  - Internal: ptr=0, hold_cnt=0, state=IDLE.
- ptr (3 bits) names the highest-priority index. Search order is ptr, ptr+1, ..., 7, 0, ..., ptr-1 (mod 8).
- State IDLE:
  - If en=1 and req!=0 at a rising edge: select the first set bit in search order.
  - On that edge: gnt=one-hot(sel), gnt_idx=sel, gnt_valid=1, hold_cnt=1, state=GRANT.
  - Latency: request sampled at edge k, grant visible after edge k.
  - If en=0 or req=0: remain in IDLE with outputs 0.
- State GRANT (checked each rising edge, in priority order):
  - en=0, or req[gnt_idx]=0: release.
  - Else MAX_HOLD!=0 and hold_cnt==MAX_HOLD: release with expired=1 for exactly one cycle.
  - Else hold_cnt increments (saturating at its maximum) and the grant is unchanged.
- Release, on the same edge:
  - gnt=0, gnt_idx=0, gnt_valid=0.
  - ptr=(gnt_idx+1) mod 8, wrapping 7 to 0.
  - state=IDLE.
- Each release is followed by at least one IDLE cycle, so there are no back-to-back grants. This is deliberate and gives a clean handover.
- No preemption. Requests from other indices during GRANT are ignored until release.
- Simultaneous owner request drop and MAX_HOLD expiry: treated as a normal release, expired=0.
- A requester that drops and re-raises its request is re-arbitrated normally. Because ptr has moved past it, it now has lowest priority.
- expired is deasserted on the cycle after its pulse.
- gnt is always one-hot or zero. gnt_valid equals |gnt.

Test Plan:
- Reset: hold rst_n=0 with req=8'hFF, en=1 -> gnt=8'h00, gnt_idx=0, gnt_valid=0, expired=0 throughout.
- Single request:
  - req=8'h01, en=1 -> one edge later gnt=8'h01, gnt_idx=0, gnt_valid=1.
  - Drop req -> next edge gnt=0.
  - Then req=8'h01 and req[1] raised together -> grant goes to index 1 (ptr=1).
- Rotation with MAX_HOLD=4: req=8'hFF held -> grant order 0,1,2,...,7,0.
  - Each grant lasts 4 cycles, then 1 idle cycle.
  - expired pulses once per grant.
  - gnt_idx wraps 7 to 0.
- Wrap search: grant index 3, release, then req=8'h0A -> next grant is index 1 (search 4,5,6,7,0,1), not 3.
- Enable drop: during a grant to index 5, set en=0 -> next edge gnt=0, expired=0.
  - With en=0 and req!=0 -> no grant.
  - Re-enable -> grant resumes from ptr=6.
- Async reset mid-grant: assert rst_n=0 between edges while gnt=8'h10 -> outputs clear immediately without a clock edge.
  - After release of reset, req=8'hFF -> first grant is index 0.
